// File: rtl/skid_buffer_pkg.sv
// Shared types and sizing for the two-entry registered skid stage.
package skid_buffer_pkg;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned STAT_W     = 32;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  // Occupancy implied by a state; illegal encodings read as empty.
  function automatic logic [SKID_CNT_W-1:0] skid_count(input skid_state_t s);
    case (s)
      SKID_BUSY: return SKID_CNT_W'(1);
      SKID_FULL: return SKID_CNT_W'(2);
      default:   return SKID_CNT_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/skid_buffer_stats.sv
// Throughput counters for the skid stage: accepted words and upstream stall cycles.
module skid_stats
  import skid_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_fire,
  input  logic              full_stall,
  output logic [STAT_W-1:0] stat_in_count,
  output logic [STAT_W-1:0] stat_full_cycles
);

  // Free-running counters; wrap naturally, unaffected by kill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_in_count    <= '0;
      stat_full_cycles <= '0;
    end else begin
      if (in_fire)    stat_in_count    <= stat_in_count + STAT_W'(1);
      if (full_stall) stat_full_cycles <= stat_full_cycles + STAT_W'(1);
    end
  end

endmodule

// File: rtl/skid_buffer.sv
// Fully registered two-entry skid buffer on a valid/ready stream.
// in_ready, out_valid, out_data and count are all flop outputs.
// Optional counters enabled by defining SKID_BUFFER_STATS_EN.
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 32
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  kill,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [DATA_SIZE-1:0]  in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_SIZE-1:0]  out_data,
  output logic [SKID_CNT_W-1:0] count
`ifdef SKID_BUFFER_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_in_count,
  output logic [STAT_W-1:0]     stat_full_cycles
`endif
);

  skid_state_t           state_q, state_d;
  logic [DATA_SIZE-1:0]  skid_q, skid_d;
  logic [DATA_SIZE-1:0]  out_data_d;
  logic                  in_fire, out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // State and data registers; handshake outputs are re-registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SKID_EMPTY;
      out_data  <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      count     <= '0;
    end else begin
      state_q   <= state_d;
      out_data  <= out_data_d;
      skid_q    <= skid_d;
      out_valid <= (state_d != SKID_EMPTY);
      in_ready  <= (state_d != SKID_FULL);
      count     <= skid_count(state_d);
    end
  end

  // Next-state and data steering; kill overrides everything and empties the stage.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data;
    skid_d     = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (in_fire) begin
          state_d    = SKID_BUSY;
          out_data_d = in_data;
        end
      end
      SKID_BUSY: begin
        if (in_fire && out_fire) begin
          out_data_d = in_data;
        end else if (in_fire) begin
          state_d = SKID_FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_fire) begin
          state_d    = SKID_BUSY;
          out_data_d = skid_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    if (kill) begin
      state_d    = SKID_EMPTY;
      out_data_d = out_data;
      skid_d     = skid_q;
    end
  end

`ifdef SKID_BUFFER_STATS_EN
  logic full_stall;
  assign full_stall = (state_q == SKID_FULL) && in_valid;

  skid_stats u_stats (
    .clk              (clk),
    .reset            (reset),
    .in_fire          (in_fire),
    .full_stall       (full_stall),
    .stat_in_count    (stat_in_count),
    .stat_full_cycles (stat_full_cycles)
  );
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Bench for skid_buffer: directed scenarios plus random traffic against a queue model.
module tb_skid_buffer;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          kill;
  logic          in_ready;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    count;
`ifdef SKID_BUFFER_STATS_EN
  logic [31:0]   stat_in_count;
  logic [31:0]   stat_full_cycles;
  int unsigned   m_in_cnt;
  int unsigned   m_full_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] model_q[$];
  logic          last_acc = 1'b0;

  always #5 clk = ~clk;

  skid_buffer #(.DATA_SIZE(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .kill      (kill),
    .in_ready  (in_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count)
`ifdef SKID_BUFFER_STATS_EN
    ,
    .stat_in_count    (stat_in_count),
    .stat_full_cycles (stat_full_cycles)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs just after the active edge.
  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic k);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    kill      = k;
  endtask

  // Monitor/scoreboard: compare outputs with the model, then advance the model by the coming edge.
  always @(negedge clk) begin : monitor
    int sz;
    logic acc;
    sz = model_q.size();
    if (reset) begin
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_in_ready",  32'(in_ready),  32'(1));
      check("rst_count",     32'(count),     32'(0));
      check("rst_out_data",  out_data,       32'(0));
      model_q.delete();
      last_acc = 1'b0;
`ifdef SKID_BUFFER_STATS_EN
      m_in_cnt   = 0;
      m_full_cnt = 0;
`endif
    end else begin
      check("in_ready",  32'(in_ready),  32'(sz < 2));
      check("out_valid", 32'(out_valid), 32'(sz > 0));
      check("count",     32'(count),     32'(sz));
      if (sz > 0) check("out_data", out_data, model_q[0]);
`ifdef SKID_BUFFER_STATS_EN
      check("stat_in",   stat_in_count,    m_in_cnt);
      check("stat_full", stat_full_cycles, m_full_cnt);
      if (sz == 2 && in_valid) m_full_cnt++;
`endif
      acc = in_valid && (sz < 2);
`ifdef SKID_BUFFER_STATS_EN
      if (acc) m_in_cnt++;
`endif
      if (out_ready && sz > 0) void'(model_q.pop_front());
      if (kill) model_q.delete();
      else if (acc) model_q.push_back(in_data);
      last_acc = acc;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1; kill = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Streaming 1..8 at full rate.
    for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i), 1'b1, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: A, B fill the stage, C waits upstream, then drain in order.
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b1, 1'b0);
    drive(1'b1, 32'hC, 1'b1, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    // Kill while full with a pending word upstream.
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    drive(1'b1, 32'h33, 1'b0, 1'b1);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    // Kill in the same cycle a word is accepted: that word is discarded.
    drive(1'b1, 32'h44, 1'b0, 1'b0);
    drive(1'b1, 32'h55, 1'b0, 1'b1);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset with two words held.
    drive(1'b1, 32'h66, 1'b0, 1'b0);
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_count", 32'(count), 32'(2));
    #1 reset = 1'b1;
    #1;
    check("async_out_valid", 32'(out_valid), 32'(0));
    check("async_in_ready",  32'(in_ready),  32'(1));
    check("async_count",     32'(count),     32'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    // Random traffic; upstream holds a word until it is taken.
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 99) < 60);
        in_data  = $urandom;
      end
      out_ready = ($urandom_range(0, 99) < 60);
      kill      = ($urandom_range(0, 99) < 3);
      if (kill && in_valid) in_valid = 1'b1;
    end

    repeat (4) drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/skid_buffer.md
Name: skid_buffer

Overview:
- Receiving end of the valid/ready stream produced by the fall-through queue.
- Fully registered two-entry skid stage. in_ready, out_valid and out_data come straight from flops, which breaks the combinational ready/valid path that fall-through queues create.
- Placed at the consumer side of fetch/decode queues and wherever a timing cut is needed without losing throughput (1 transfer/cycle sustained).

Parameters:
DATA_SIZE, 32, payload width in bits

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state
kill  input  1  synchronous flush; discards all held entries
in_ready  output  1  registered; buffer can accept a word this cycle
in_valid  input  1  upstream has a word
in_data  input  DATA_SIZE  upstream payload
out_ready  input  1  downstream accepts out_data this cycle
out_valid  output  1  registered; out_data holds a valid word
out_data  output  DATA_SIZE  registered head word
count  output  2  number of held words, 0..2

Behaviour:
- One clock; reset is asynchronous and active-high, ports clk and reset.
- in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- State register, 3 states:
  - EMPTY: out_valid=0, in_ready=1, count=0.
  - BUSY: out_valid=1, in_ready=1, count=1.
  - FULL: out_valid=1, in_ready=0, count=2.
- All three outputs decode from flops only. No combinational path from in_valid/out_ready to any output.
- Reset values: state=EMPTY, out_valid=0, in_ready=1, count=0, out_data=0, skid register=0.
- Transfers presented while reset is asserted are dropped.
- Transitions (no kill):
  - EMPTY: in_fire -> BUSY, out_data<=in_data. Otherwise stay.
  - BUSY, in_fire && out_fire -> BUSY, out_data<=in_data.
  - BUSY, in_fire only -> FULL, skid<=in_data.
  - BUSY, out_fire only -> EMPTY.
  - BUSY, neither -> stay.
  - FULL: out_fire -> BUSY, out_data<=skid. in_fire is impossible here because in_ready=0.
- Latency: a word accepted in cycle N is visible on out_data in cycle N+1 at the earliest.
- Ordering: strict FIFO; the skid word never overtakes out_data.
- kill (synchronous) has priority over every transfer:
  - Next state is EMPTY.
  - An in_fire in the kill cycle is consumed upstream but discarded.
  - An out_fire in the kill cycle completes normally, since downstream already sampled the data.
  - Data registers need not clear on kill.
- out_data must stay stable while out_valid && !out_ready.
- Upstream must hold in_valid/in_data stable until accepted.
- Illegal state encodings recover to EMPTY.

Optional Feature:
- Macro SKID_BUFFER_STATS_EN.
- When defined, adds output ports:
  - stat_in_count[31:0]: number of in_fire.
  - stat_full_cycles[31:0]: cycles in FULL with in_valid=1, i.e. upstream stalled.
- Both counters clear on reset, do not clear on kill, and wrap modulo 2^32.
- When undefined, the ports and counter logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package skid_buffer_pkg:
  - typedef enum logic [1:0] skid_state_t {SKID_EMPTY=0, SKID_BUSY=1, SKID_FULL=2}.
  - localparam SKID_DEPTH=2.
- One sub-module, skid_stats, holds the two counters. It is instantiated only under SKID_BUFFER_STATS_EN.

Test Plan:
- Reset: assert reset mid-run with 2 words held -> out_valid=0, in_ready=1, count=0 immediately (asynchronous), before the next clk edge.
- Streaming: in_valid=1 with data 1..8 on consecutive cycles, out_ready=1 -> out_data 1..8 on consecutive cycles starting 1 cycle later, in_ready always 1, count stays 1.
- Backpressure:
  - Push 0xA, 0xB, 0xC with out_ready=0 -> count=2 after 0xB, in_ready=0, 0xC held upstream.
  - Release out_ready -> outputs 0xA, 0xB, 0xC in order.
- Simultaneous in FULL: out_fire with in_valid=1 -> count 2->1, in_ready rises the next cycle, no word lost or duplicated.
- Kill: FULL holding 0x11, 0x22, kill=1 with in_valid=1 data 0x33 -> next cycle EMPTY, out_valid=0; 0x33 never appears.
- Stats (SKID_BUFFER_STATS_EN): hold FULL with in_valid=1 for 5 cycles after 3 accepts -> stat_in_count=3, stat_full_cycles=5.
